// File: rtl/mux_data_source_reg.sv
// Registered write-back data-source selector: latched select, trapped illegal
// selects with a sticky error flag, and a valid/ready output register.
module mux_data_source_reg #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 10,
    parameter int SEL_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      sel_load,
    input  logic                      capture,
    output logic                      capture_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          sel_q,
    output logic                      sel_err,
    input  logic                      err_clear
);

    localparam logic [SEL_W:0] NUM_SRC_L = NUM_SRC[SEL_W:0];

    logic              sel_legal;
    logic [SEL_W-1:0]  sel_eff;
    logic [DATA_W-1:0] data_sel;
    logic              accept;

    assign sel_legal     = ({1'b0, sel_in} < NUM_SRC_L);
    // Same-cycle bypass lets a select load and a capture share one cycle.
    assign sel_eff       = (sel_load && sel_legal) ? sel_in : sel_q;
    assign capture_ready = !out_valid || out_ready;
    assign accept        = capture && capture_ready;

    always_comb begin
        data_sel = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel_eff == k[SEL_W-1:0]) begin
                data_sel = src_in[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= '0;
            sel_err   <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (sel_load && sel_legal) begin
                sel_q <= sel_in;
            end
            // An illegal load in the same cycle as a clear leaves the flag set.
            if (sel_load && !sel_legal) begin
                sel_err <= 1'b1;
            end else if (err_clear) begin
                sel_err <= 1'b0;
            end
            if (accept) begin
                data_out  <= data_sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
